// File: rtl/zorro_pkg.sv
// ---------------------------------------------------------------------------
// zorro_pkg
// Shared definitions for the Zorro III slave-cycle responder:
//   - state_t       : slave FSM states
//   - Z3_BASE_HI/LO : address bits compared against the autoconfig base
//   - SYNC_STAGES   : depth of the bus-input synchronizers
//   - decode_hit()  : card-select decode used in DECODE
// ---------------------------------------------------------------------------
package zorro_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      MISS    = 3'd2,
      WAIT_DS = 3'd3,
      ACCESS  = 3'd4,
      TERM    = 3'd5
   } state_t;

   localparam int Z3_BASE_HI  = 31;
   localparam int Z3_BASE_LO  = 24;
   localparam int SYNC_STAGES = 2;

   // The card only answers once configured and while it is not itself
   // mastering the bus.
   function automatic logic decode_hit(input logic       configured,
                                       input logic       bmaster,
                                       input logic [7:0] za_hi,
                                       input logic [7:0] base);
      return configured & ~bmaster & (za_hi == base);
   endfunction

endpackage

// File: rtl/zorro_z3_slave_if.sv
// ---------------------------------------------------------------------------
// zorro_z3_slave_if
// Zorro III bus-side signals seen by the slave responder.
//   FCS_n, DS_n[3:0], READ, ZA[31:2] : driven by the host (master modport)
//   SLAVE_n, DTACK_n, DOE            : driven by the card  (slave modport)
// ---------------------------------------------------------------------------
interface zorro_z3_slave_if;

   logic        FCS_n;
   logic [3:0]  DS_n;
   logic        READ;
   logic [31:2] ZA;
   logic        SLAVE_n;
   logic        DTACK_n;
   logic        DOE;

   modport master (
      output FCS_n, DS_n, READ, ZA,
      input  SLAVE_n, DTACK_n, DOE
   );

   modport slave (
      input  FCS_n, DS_n, READ, ZA,
      output SLAVE_n, DTACK_n, DOE
   );

endinterface

// File: rtl/zorro_sync.sv
// ---------------------------------------------------------------------------
// zorro_sync
// Multi-flop synchronizer (SYNC_STAGES deep) for asynchronous bus inputs.
//   CLK, RESET_n : clock, asynchronous active-low reset
//   d            : asynchronous input, WIDTH bits
//   q            : synchronized output, RST_VAL while in reset
// ---------------------------------------------------------------------------
module zorro_sync
   import zorro_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [SYNC_STAGES];

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_r[i] <= RST_VAL;
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/zorro_z3_slave.sv
// ---------------------------------------------------------------------------
// zorro_z3_slave
// Zorro III slave-cycle responder: decodes the card base, claims the cycle
// with SLAVE_n, runs one local register access and terminates with DTACK_n.
//   CLK, RESET_n        : 25 MHz clock, asynchronous active-low reset
//   CONFIGURED          : autoconfig complete, enables decode
//   BASE_ADDR[7:0]      : assigned base, compared with ZA[31:24]
//   BMASTER             : card owns the bus, inhibits decode
//   bus (slave modport) : FCS_n, DS_n, READ, ZA in; SLAVE_n, DTACK_n, DOE out
//   REG_REQ/WR/ADDR/BE  : local register request (level) and its attributes
//   REG_ACK             : local access done, one-cycle pulse
//   TIMEOUT             : one-cycle pulse on forced termination
// Optional feature: define ZORRO_SLAVE_TIMEOUT_EN to force termination after
// TIMEOUT_CYCLES in ACCESS; otherwise ACCESS waits for REG_ACK indefinitely
// and TIMEOUT is tied low.
// ---------------------------------------------------------------------------
module zorro_z3_slave
   import zorro_pkg::*;
#(
   parameter int ADDR_W         = 6,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic              CONFIGURED,
   input  logic [7:0]        BASE_ADDR,
   input  logic              BMASTER,
   zorro_z3_slave_if.slave   bus,
   output logic              REG_REQ,
   output logic              REG_WR,
   output logic [ADDR_W-1:0] REG_ADDR,
   output logic [3:0]        REG_BE,
   input  logic              REG_ACK,
   output logic              TIMEOUT
);

   logic              fcs_n_s, read_s;
   logic [3:0]        ds_n_s;
   logic              fcs_s;
   logic [3:0]        ds_s;

   state_t            state_r, state_nxt_s;
   logic              fcs_prev_r;
   logic [7:0]        za_hi_r, za_hi_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic              read_lat_r, read_lat_nxt_s;
   logic              slave_n_r, slave_n_nxt_s;
   logic              dtack_n_r, dtack_n_nxt_s;
   logic              doe_r, doe_nxt_s;
   logic              req_r, req_nxt_s;
   logic              wr_r, wr_nxt_s;
   logic [3:0]        be_r, be_nxt_s;

   zorro_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_fcs (
      .CLK(CLK), .RESET_n(RESET_n), .d(bus.FCS_n), .q(fcs_n_s));
   zorro_sync #(.WIDTH(4), .RST_VAL(4'hF)) u_sync_ds (
      .CLK(CLK), .RESET_n(RESET_n), .d(bus.DS_n), .q(ds_n_s));
   zorro_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_read (
      .CLK(CLK), .RESET_n(RESET_n), .d(bus.READ), .q(read_s));

   assign fcs_s = ~fcs_n_s;
   assign ds_s  = ~ds_n_s;

`ifdef ZORRO_SLAVE_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt_r;
   logic             timeout_r, timeout_nxt_s;

   // Cycles spent in ACCESS; held at zero everywhere else so each entry starts clean.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         cnt_r <= '0;
      end else if (state_r != ACCESS) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + 1'b1;
      end
   end

   assign TIMEOUT = timeout_r;
`else
   assign TIMEOUT = 1'b0;
`endif

   // Next state and next output values; every register holds by default.
   always_comb begin
      state_nxt_s    = state_r;
      za_hi_nxt_s    = za_hi_r;
      addr_nxt_s     = addr_r;
      read_lat_nxt_s = read_lat_r;
      slave_n_nxt_s  = slave_n_r;
      dtack_n_nxt_s  = dtack_n_r;
      doe_nxt_s      = doe_r;
      req_nxt_s      = req_r;
      wr_nxt_s       = wr_r;
      be_nxt_s       = be_r;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
      timeout_nxt_s  = 1'b0;
`endif
      // Losing FCS before TERM is a host abort: release everything and go idle.
      if (!fcs_s && (state_r == DECODE || state_r == WAIT_DS || state_r == ACCESS)) begin
         state_nxt_s   = IDLE;
         slave_n_nxt_s = 1'b1;
         dtack_n_nxt_s = 1'b1;
         doe_nxt_s     = 1'b0;
         req_nxt_s     = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               // ZA is stable by the time the synchronized FCS edge is seen.
               if (fcs_s && !fcs_prev_r) begin
                  za_hi_nxt_s    = bus.ZA[Z3_BASE_HI:Z3_BASE_LO];
                  addr_nxt_s     = bus.ZA[ADDR_W+1:2];
                  read_lat_nxt_s = read_s;
                  state_nxt_s    = DECODE;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            DECODE: begin
               if (decode_hit(CONFIGURED, BMASTER, za_hi_r, BASE_ADDR)) begin
                  slave_n_nxt_s = 1'b0;
                  state_nxt_s   = WAIT_DS;
               end else begin
                  state_nxt_s = MISS;
               end
            end
            MISS: begin
               if (!fcs_s) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = MISS;
               end
            end
            WAIT_DS: begin
               if (|ds_s) begin
                  be_nxt_s    = ds_s;
                  wr_nxt_s    = ~read_lat_r;
                  req_nxt_s   = 1'b1;
                  doe_nxt_s   = read_lat_r;
                  state_nxt_s = ACCESS;
               end else begin
                  state_nxt_s = WAIT_DS;
               end
            end
            ACCESS: begin
               if (REG_ACK) begin
                  req_nxt_s     = 1'b0;
                  dtack_n_nxt_s = 1'b0;
                  state_nxt_s   = TERM;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
               end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  req_nxt_s     = 1'b0;
                  dtack_n_nxt_s = 1'b0;
                  timeout_nxt_s = 1'b1;
                  state_nxt_s   = TERM;
`endif
               end else begin
                  state_nxt_s = ACCESS;
               end
            end
            TERM: begin
               if (!fcs_s) begin
                  slave_n_nxt_s = 1'b1;
                  dtack_n_nxt_s = 1'b1;
                  doe_nxt_s     = 1'b0;
                  state_nxt_s   = IDLE;
               end else begin
                  state_nxt_s = TERM;
               end
            end
            default: begin
               state_nxt_s   = IDLE;
               slave_n_nxt_s = 1'b1;
               dtack_n_nxt_s = 1'b1;
               doe_nxt_s     = 1'b0;
               req_nxt_s     = 1'b0;
            end
         endcase
      end
   end

   // FSM state register plus FCS edge-detect history.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r    <= IDLE;
         fcs_prev_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         fcs_prev_r <= fcs_s;
      end
   end

   // Registered bus and local-port outputs together with latched cycle attributes.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         za_hi_r    <= 8'h00;
         addr_r     <= '0;
         read_lat_r <= 1'b0;
         slave_n_r  <= 1'b1;
         dtack_n_r  <= 1'b1;
         doe_r      <= 1'b0;
         req_r      <= 1'b0;
         wr_r       <= 1'b0;
         be_r       <= 4'h0;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
         timeout_r  <= 1'b0;
`endif
      end else begin
         za_hi_r    <= za_hi_nxt_s;
         addr_r     <= addr_nxt_s;
         read_lat_r <= read_lat_nxt_s;
         slave_n_r  <= slave_n_nxt_s;
         dtack_n_r  <= dtack_n_nxt_s;
         doe_r      <= doe_nxt_s;
         req_r      <= req_nxt_s;
         wr_r       <= wr_nxt_s;
         be_r       <= be_nxt_s;
`ifdef ZORRO_SLAVE_TIMEOUT_EN
         timeout_r  <= timeout_nxt_s;
`endif
      end
   end

   assign bus.SLAVE_n = slave_n_r;
   assign bus.DTACK_n = dtack_n_r;
   assign bus.DOE     = doe_r;
   assign REG_REQ     = req_r;
   assign REG_WR      = wr_r;
   assign REG_ADDR    = addr_r;
   assign REG_BE      = be_r;

endmodule

// File: tb/tb_zorro_z3_slave.sv
// ---------------------------------------------------------------------------
// tb_zorro_z3_slave
// Directed bench for zorro_z3_slave: reset values, hit write, hit byte read,
// three miss flavours, host abort with late ACK, ACCESS timeout behaviour
// (forced termination with ZORRO_SLAVE_TIMEOUT_EN, indefinite wait without)
// and asynchronous reset in the middle of an access.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_zorro_z3_slave;

   logic       CLK = 1'b0;
   logic       RESET_n;
   logic       CONFIGURED;
   logic [7:0] BASE_ADDR;
   logic       BMASTER;
   logic       REG_REQ;
   logic       REG_WR;
   logic [5:0] REG_ADDR;
   logic [3:0] REG_BE;
   logic       REG_ACK;
   logic       TIMEOUT;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int n;
   logic bad;

   zorro_z3_slave_if bus ();

   zorro_z3_slave #(.ADDR_W(6), .TIMEOUT_CYCLES(8)) dut (
      .CLK       (CLK),
      .RESET_n   (RESET_n),
      .CONFIGURED(CONFIGURED),
      .BASE_ADDR (BASE_ADDR),
      .BMASTER   (BMASTER),
      .bus       (bus),
      .REG_REQ   (REG_REQ),
      .REG_WR    (REG_WR),
      .REG_ADDR  (REG_ADDR),
      .REG_BE    (REG_BE),
      .REG_ACK   (REG_ACK),
      .TIMEOUT   (TIMEOUT)
   );

   always #20 CLK = ~CLK;

   task automatic tick(input int k);
      repeat (k) @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_cycle(input logic [31:0] za_v, input logic rd, input logic [3:0] ds_n);
      bus.ZA    = za_v[31:2];
      bus.READ  = rd;
      bus.DS_n  = ds_n;
      bus.FCS_n = 1'b0;
   endtask

   task automatic end_cycle();
      bus.FCS_n = 1'b1;
      bus.DS_n  = 4'hF;
   endtask

   // Bounded wait for SLAVE_n to assert; an expired budget is a failed check.
   task automatic wait_claim(input string tag);
      int k;
      k = 0;
      while (bus.SLAVE_n !== 1'b0 && k < 8) begin
         tick(1);
         k++;
      end
      chk(tag, {31'd0, k < 8}, 32'd1);
   endtask

   initial begin
      RESET_n    = 1'b0;
      CONFIGURED = 1'b1;
      BASE_ADDR  = 8'h40;
      BMASTER    = 1'b0;
      REG_ACK    = 1'b0;
      bus.FCS_n  = 1'b1;
      bus.DS_n   = 4'hF;
      bus.READ   = 1'b1;
      bus.ZA     = 30'd0;

      // Reset values
      tick(2);
      chk("rst_slave_n", bus.SLAVE_n, 32'd1);
      chk("rst_dtack_n", bus.DTACK_n, 32'd1);
      chk("rst_doe",     bus.DOE,     32'd0);
      chk("rst_req",     REG_REQ,     32'd0);
      chk("rst_wr",      REG_WR,      32'd0);
      chk("rst_addr",    REG_ADDR,    32'd0);
      chk("rst_be",      REG_BE,      32'd0);
      chk("rst_timeout", TIMEOUT,     32'd0);
      RESET_n = 1'b1;
      tick(3);

      // Hit write, all four bytes, ACK three cycles after REQ
      start_cycle(32'h4000_0010, 1'b0, 4'b0000);
      wait_claim("wr_claim");
      chk("wr_req_after_claim", REG_REQ, 32'd0);
      tick(1);
      chk("wr_req",   REG_REQ,     32'd1);
      chk("wr_addr",  REG_ADDR,    32'd4);
      chk("wr_be",    REG_BE,      32'hF);
      chk("wr_wr",    REG_WR,      32'd1);
      chk("wr_doe",   bus.DOE,     32'd0);
      chk("wr_dtack_pre", bus.DTACK_n, 32'd1);
      tick(2);
      chk("wr_req_hold", REG_REQ, 32'd1);
      REG_ACK = 1'b1;
      tick(1);
      REG_ACK = 1'b0;
      chk("wr_dtack", bus.DTACK_n, 32'd0);
      chk("wr_req_drop", REG_REQ, 32'd0);
      tick(2);
      chk("wr_dtack_hold", bus.DTACK_n, 32'd0);
      chk("wr_slave_hold", bus.SLAVE_n, 32'd0);
      end_cycle();
      tick(2);
      chk("wr_dtack_pre_release", bus.DTACK_n, 32'd0);
      tick(1);
      chk("wr_dtack_release", bus.DTACK_n, 32'd1);
      chk("wr_slave_release", bus.SLAVE_n, 32'd1);

      // Hit read, byte lane 0 only
      tick(1);
      start_cycle(32'h4000_0020, 1'b1, 4'b1110);
      wait_claim("rd_claim");
      tick(1);
      chk("rd_req",  REG_REQ,  32'd1);
      chk("rd_be",   REG_BE,   32'h1);
      chk("rd_wr",   REG_WR,   32'd0);
      chk("rd_doe",  bus.DOE,  32'd1);
      chk("rd_addr", REG_ADDR, 32'd8);
      REG_ACK = 1'b1;
      tick(1);
      REG_ACK = 1'b0;
      chk("rd_dtack",    bus.DTACK_n, 32'd0);
      chk("rd_doe_term", bus.DOE,     32'd1);
      end_cycle();
      tick(3);
      chk("rd_doe_release",   bus.DOE,     32'd0);
      chk("rd_dtack_release", bus.DTACK_n, 32'd1);

      // Misses: wrong base, unconfigured, card is bus master
      for (int m = 0; m < 3; m++) begin
         if (m == 1) CONFIGURED = 1'b0;
         if (m == 2) BMASTER = 1'b1;
         bad = 1'b0;
         start_cycle((m == 0) ? 32'h4100_0010 : 32'h4000_0010, 1'b0, 4'b0000);
         for (int c = 0; c < 10; c++) begin
            tick(1);
            if (bus.SLAVE_n !== 1'b1 || bus.DTACK_n !== 1'b1 || REG_REQ !== 1'b0) bad = 1'b1;
         end
         chk($sformatf("miss_%0d_idle", m), {31'd0, bad}, 32'd0);
         CONFIGURED = 1'b1;
         BMASTER    = 1'b0;
         end_cycle();
         tick(4);
      end

      // Host abort in ACCESS, then a late ACK, then a normal cycle
      start_cycle(32'h4000_0010, 1'b0, 4'b0000);
      wait_claim("ab_claim");
      tick(1);
      chk("ab_req", REG_REQ, 32'd1);
      end_cycle();
      tick(3);
      chk("ab_req_drop",  REG_REQ,     32'd0);
      chk("ab_slave_rel", bus.SLAVE_n, 32'd1);
      chk("ab_no_dtack",  bus.DTACK_n, 32'd1);
      REG_ACK = 1'b1;
      tick(1);
      REG_ACK = 1'b0;
      chk("ab_late_ack_dtack", bus.DTACK_n, 32'd1);
      chk("ab_late_ack_req",   REG_REQ,     32'd0);
      tick(2);
      start_cycle(32'h4000_0030, 1'b0, 4'b0000);
      wait_claim("ab_next_claim");
      tick(1);
      chk("ab_next_addr", REG_ADDR, 32'hC);
      chk("ab_next_req",  REG_REQ,  32'd1);
      REG_ACK = 1'b1;
      tick(1);
      REG_ACK = 1'b0;
      chk("ab_next_dtack", bus.DTACK_n, 32'd0);
      end_cycle();
      tick(3);
      chk("ab_next_release", bus.DTACK_n, 32'd1);

`ifdef ZORRO_SLAVE_TIMEOUT_EN
      // Forced termination eight cycles after REQ rises
      start_cycle(32'h4000_0010, 1'b1, 4'b0000);
      wait_claim("to_claim");
      tick(1);
      chk("to_req", REG_REQ, 32'd1);
      tick(7);
      chk("to_dtack_pre",   bus.DTACK_n, 32'd1);
      chk("to_timeout_pre", TIMEOUT,     32'd0);
      tick(1);
      chk("to_dtack",   bus.DTACK_n, 32'd0);
      chk("to_timeout", TIMEOUT,     32'd1);
      chk("to_req_drop", REG_REQ,    32'd0);
      tick(1);
      chk("to_timeout_pulse", TIMEOUT, 32'd0);
      end_cycle();
      tick(4);
      // ACK in the final cycle wins over the timeout
      start_cycle(32'h4000_0010, 1'b1, 4'b0000);
      wait_claim("to_ack_claim");
      tick(1);
      tick(7);
      REG_ACK = 1'b1;
      tick(1);
      REG_ACK = 1'b0;
      chk("to_ack_dtack",   bus.DTACK_n, 32'd0);
      chk("to_ack_timeout", TIMEOUT,     32'd0);
      end_cycle();
      tick(4);
`else
      // Without the timeout feature ACCESS waits indefinitely
      start_cycle(32'h4000_0010, 1'b1, 4'b0000);
      wait_claim("nt_claim");
      tick(20);
      chk("nt_req_hold",   REG_REQ,     32'd1);
      chk("nt_dtack",      bus.DTACK_n, 32'd1);
      chk("nt_timeout",    TIMEOUT,     32'd0);
      REG_ACK = 1'b1;
      tick(1);
      REG_ACK = 1'b0;
      chk("nt_ack_dtack", bus.DTACK_n, 32'd0);
      end_cycle();
      tick(4);
`endif

      // Asynchronous reset in the middle of a read access
      start_cycle(32'h4000_0024, 1'b1, 4'b0000);
      wait_claim("rs_claim");
      tick(1);
      chk("rs_req", REG_REQ, 32'd1);
      chk("rs_doe", bus.DOE, 32'd1);
      #2 RESET_n = 1'b0;
      #1;
      chk("rs_req_clr",   REG_REQ,     32'd0);
      chk("rs_slave_clr", bus.SLAVE_n, 32'd1);
      chk("rs_doe_clr",   bus.DOE,     32'd0);
      chk("rs_dtack_clr", bus.DTACK_n, 32'd1);
      chk("rs_addr_clr",  REG_ADDR,    32'd0);
      chk("rs_be_clr",    REG_BE,      32'd0);
      end_cycle();
      tick(1);
      RESET_n = 1'b1;
      tick(4);
      chk("rs_idle_slave", bus.SLAVE_n, 32'd1);
      chk("rs_idle_req",   REG_REQ,     32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
